// File: rtl/sccb_sender.sv
// sccb_sender: SCCB (3-wire, write-only) master that shifts out one
// {DEV_ID, x, addr, x, value, x} phase-write per request.
// All bus/handshake outputs are registered, so the pins lag the state by one
// cycle.
// Optional feature: define SCCB_ACK_CHECK_EN to add the nack output, which
// samples sio_d_in in the don't-care slots.
module sccb_sender #(
   parameter int unsigned  QTR_DIV  = 63,
   parameter logic [7:0]   DEV_ID   = 8'h42,
   parameter logic [15:0]  INIT_DLY = 16'd25000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       data_vld,
   input  logic [7:0] addr,
   input  logic [7:0] value,
   output logic       SCCB_done,
   output logic       busy,
   output logic       sio_c,
   output logic       sio_d_out,
   output logic       sio_d_oe,
   input  logic       sio_d_in
`ifdef SCCB_ACK_CHECK_EN
   ,
   output logic       nack
`endif
);

   localparam int QW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;

   typedef enum logic [2:0] {
      WAIT_INIT, IDLE, LOAD, START, BITS, STOP, DONE
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   init_q, init_d;
   logic [QW-1:0] qcnt_q, qcnt_d;
   logic [1:0]    ph_q, ph_d;
   logic [4:0]    bit_q, bit_d;
   logic [26:0]   sh_q, sh_d;

   logic sio_c_q, sio_c_d;
   logic sio_d_q, sio_d_d;
   logic sio_oe_q, sio_oe_d;
   logic done_q, done_d;
   logic busy_q, busy_d;

   logic qwrap;
   logic ack_slot;

   assign qwrap    = (qcnt_q == QW'(QTR_DIV - 1));
   assign ack_slot = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26);

   assign sio_c     = sio_c_q;
   assign sio_d_out = sio_d_q;
   assign sio_d_oe  = sio_oe_q;
   assign SCCB_done = done_q;
   assign busy      = busy_q;

   // State, counters and shift register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= WAIT_INIT;
         init_q  <= '0;
         qcnt_q  <= '0;
         ph_q    <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
      end else begin
         state_q <= state_d;
         init_q  <= init_d;
         qcnt_q  <= qcnt_d;
         ph_q    <= ph_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
      end
   end

   // Registered pin/handshake outputs; reset forces the idle-high bus at once
   always_ff @(posedge clk) begin
      if (rst) begin
         sio_c_q  <= 1'b1;
         sio_d_q  <= 1'b1;
         sio_oe_q <= 1'b1;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         sio_c_q  <= sio_c_d;
         sio_d_q  <= sio_d_d;
         sio_oe_q <= sio_oe_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   // Next-state and bus waveform per state/quarter
   always_comb begin
      state_d  = state_q;
      init_d   = init_q;
      qcnt_d   = qcnt_q;
      ph_d     = ph_q;
      bit_d    = bit_q;
      sh_d     = sh_q;
      sio_c_d  = 1'b1;
      sio_d_d  = 1'b1;
      sio_oe_d = 1'b1;
      done_d   = 1'b0;
      busy_d   = 1'b0;

      // quarter timing shared by START/BITS/STOP
      if (state_q == START || state_q == BITS || state_q == STOP) begin
         if (qwrap) begin
            qcnt_d = '0;
            ph_d   = ph_q + 2'd1;
         end else begin
            qcnt_d = qcnt_q + QW'(1);
         end
      end

      case (state_q)
         WAIT_INIT: begin
            if (init_q == INIT_DLY - 16'd1) begin
               init_d  = '0;
               state_d = DONE;
            end else begin
               init_d = init_q + 16'd1;
            end
         end
         IDLE: begin
            // the registered done pulse is still on the pin in the first
            // IDLE cycle; a request coincident with it is dropped
            if (data_vld && !done_q) state_d = LOAD;
         end
         LOAD: begin
            busy_d  = 1'b1;
            sh_d    = {DEV_ID, 1'b1, addr, 1'b1, value, 1'b1};
            qcnt_d  = '0;
            ph_d    = '0;
            bit_d   = '0;
            state_d = START;
         end
         START: begin
            busy_d  = 1'b1;
            sio_c_d = ~ph_q[1];
            sio_d_d = (ph_q == 2'd0);
            if (qwrap && ph_q == 2'd3) state_d = BITS;
         end
         BITS: begin
            busy_d   = 1'b1;
            sio_c_d  = ph_q[1];
            sio_d_d  = sh_q[26];
            sio_oe_d = ~ack_slot;
            if (qwrap && ph_q == 2'd3) begin
               sh_d = {sh_q[25:0], 1'b0};
               if (bit_q == 5'd26) begin
                  bit_d   = '0;
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + 5'd1;
               end
            end
         end
         STOP: begin
            busy_d  = 1'b1;
            sio_c_d = (ph_q != 2'd0);
            sio_d_d = ph_q[1];
            if (qwrap && ph_q == 2'd3) state_d = DONE;
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = WAIT_INIT;
      endcase
   end

`ifdef SCCB_ACK_CHECK_EN
   logic nack_q;
   assign nack = nack_q;

   // Sticky NACK: sampled at the end of SCL-high's first quarter of each
   // don't-care slot, cleared when the next write is loaded
   always_ff @(posedge clk) begin
      if (rst)
         nack_q <= 1'b0;
      else if (state_q == LOAD)
         nack_q <= 1'b0;
      else if (state_q == BITS && ph_q == 2'd2 && qwrap && ack_slot && sio_d_in)
         nack_q <= 1'b1;
   end
`else
   logic unused_sio_d_in;
   assign unused_sio_d_in = sio_d_in;
`endif

endmodule

// File: tb/tb_sccb_sender.sv
// tb_sccb_sender: directed sequence with random addr/value; decodes the SCCB
// waveform from the pins and compares against bytes/timing derived from the
// protocol rules.
module tb_sccb_sender;
   localparam int          Q    = 4;
   localparam logic [15:0] IDLY = 16'd10;
   localparam logic [7:0]  DEV  = 8'h42;
   localparam int          LAT  = 3 + 116 * Q;

   logic clk = 1'b0;
   logic rst, data_vld, sio_d_in;
   logic [7:0] addr, value;
   logic SCCB_done, busy, sio_c, sio_d_out, sio_d_oe;
`ifdef SCCB_ACK_CHECK_EN
   logic nack;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   sccb_sender #(.QTR_DIV(Q), .DEV_ID(DEV), .INIT_DLY(IDLY)) dut (
      .clk(clk), .rst(rst), .data_vld(data_vld), .addr(addr), .value(value),
      .SCCB_done(SCCB_done), .busy(busy), .sio_c(sio_c), .sio_d_out(sio_d_out),
      .sio_d_oe(sio_d_oe), .sio_d_in(sio_d_in)
`ifdef SCCB_ACK_CHECK_EN
      , .nack(nack)
`endif
   );

   always #20 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // after reset release: exactly one done pulse, 11 cycles later, never busy
   task automatic check_init();
      int cnt = 0, first = -1;
      logic bsy = 1'b0;
      for (int n = 0; n <= 20; n++) begin
         @(negedge clk);
         if (SCCB_done) begin cnt++; if (first < 0) first = n; end
         bsy |= busy;
      end
      chk("init_done_cnt", cnt, 1);
      chk("init_done_cycle", first, int'(IDLY) + 1);
      chk("init_busy", bsy, 0);
   endtask

   // mode: 0 normal, 1 data_vld mid-BITS, 2 data_vld with done pulse,
   //       3 reset abort in bit 10, 4 NACK injected in bit 17, 5 nack clear check
   task automatic run_write(input logic [7:0] a, input logic [7:0] v, input int mode);
      logic [26:0] exp_bits, got, oeg, exp_oe;
      logic prev_c, prev_d, started, stopped, busy_bad, aborted;
      int rises, done_n, done_cnt, post;
      exp_bits = {DEV, 1'b1, a, 1'b1, v, 1'b1};
      for (int i = 0; i < 27; i++) exp_oe[26-i] = ((i % 9) != 8);
      got = '0; oeg = '0;
      prev_c = 1'b1; prev_d = 1'b1; started = 0; stopped = 0; busy_bad = 0; aborted = 0;
      rises = 0; done_n = 0; done_cnt = 0;
      post = (mode == 2) ? 30 : 1;

      @(posedge clk); #1 data_vld = 1'b1; addr = 8'($urandom); value = 8'($urandom);
      @(posedge clk); #1 data_vld = 1'b0; addr = a; value = v;
      for (int n = 1; n <= 700; n++) begin
         @(negedge clk);
         if (!started && prev_c && sio_c && prev_d && !sio_d_out) started = 1;
         if (started && rises == 27 && prev_c && sio_c && !prev_d && sio_d_out) stopped = 1;
         if (started && !prev_c && sio_c && rises < 27) begin
            got[26-rises] = sio_d_out;
            oeg[26-rises] = sio_d_oe;
            rises++;
         end
         if (SCCB_done) begin done_cnt++; if (done_n == 0) done_n = n; end
         if (n >= 2 && n < LAT && !busy) busy_bad = 1;
         if (done_n != 0 && busy) busy_bad = 1;
         if (mode == 1) data_vld = (n == 200);
         if (mode == 2 && n == done_n) data_vld = 1'b1;
         if (mode == 2 && done_n != 0 && n == done_n + 1) data_vld = 1'b0;
         sio_d_in = (mode == 4) && (rises == 18);
`ifdef SCCB_ACK_CHECK_EN
         if (mode == 5 && n == 3) chk("nack_cleared", nack, 0);
`endif
         if (mode == 3 && rises == 11) begin
            rst = 1'b1;
            aborted = 1;
            break;
         end
         prev_c = sio_c; prev_d = sio_d_out;
         if (done_n != 0 && n >= done_n + post) break;
      end
      data_vld = 1'b0;
      sio_d_in = 1'b0;

      if (mode == 3) begin
         chk("abort_reached", aborted, 1);
         @(negedge clk);
         chk("abort_bus", {sio_c, sio_d_out, sio_d_oe, busy, SCCB_done}, 5'b11100);
         chk("abort_no_done", done_cnt, 0);
         @(posedge clk); #1 rst = 1'b0;
         check_init();
      end else begin
         chk("start_seen", started, 1);
         chk("stop_seen", stopped, 1);
         chk("bit_count", rises, 27);
         chk("bytes", {got[26:19], got[17:10], got[8:1]}, {DEV, a, v});
         chk("oe_pattern", oeg, exp_oe);
         chk("latency", done_n, LAT);
         chk("done_once", done_cnt, 1);
         chk("busy_window", busy_bad, 0);
`ifdef SCCB_ACK_CHECK_EN
         chk("nack_after", nack, (mode == 4) ? 1 : 0);
`endif
      end
   endtask

   initial begin
      rst = 1'b1; data_vld = 1'b0; addr = '0; value = '0; sio_d_in = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {sio_c, sio_d_out, sio_d_oe, SCCB_done, busy}, 5'b11100);
`ifdef SCCB_ACK_CHECK_EN
      chk("reset_nack", nack, 0);
`endif
      @(posedge clk); #1 rst = 1'b0;
      check_init();

      // three back-to-back writes, each request 2 cycles after the done pulse
      run_write(8'h12, 8'h14, 0);
      run_write(8'($urandom), 8'($urandom), 0);
      run_write(8'($urandom), 8'($urandom), 0);
      // ignored requests
      run_write(8'($urandom), 8'($urandom), 1);
      run_write(8'($urandom), 8'($urandom), 2);
`ifdef SCCB_ACK_CHECK_EN
      run_write(8'($urandom), 8'($urandom), 4);
      run_write(8'($urandom), 8'($urandom), 5);
`endif
      // abort mid-transfer, then recover
      run_write(8'($urandom), 8'($urandom), 3);
      run_write(8'hA5, 8'h5A, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/sccb_sender.md
SCCB_SENDER -- requirements
Module: sccb_sender

Interface
REQ-001 SHALL have parameter QTR_DIV, default 63: clk cycles per SCL quarter-period; SCL period = 4*QTR_DIV, about 99 kHz at 25 MHz.
REQ-002 SHALL have parameter DEV_ID, default 8'h42: 8-bit SCCB write ID.
REQ-003 SHALL have parameter INIT_DLY, default 16'd25000: clk cycles from reset release to the first SCCB_done request.
REQ-004 SHALL have port clk, input, 1: single system clock, 25 MHz.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port data_vld, input, 1: one-cycle request for a write.
REQ-007 SHALL have port addr, input, 8: register sub-address.
REQ-008 SHALL have port value, input, 8: register write data.
REQ-009 SHALL have port SCCB_done, output, 1: one-cycle pulse meaning ready for the next write.
REQ-010 SHALL have port busy, output, 1: high while a transfer is in progress.
REQ-011 SHALL have port sio_c, output, 1: SCCB clock, always driven.
REQ-012 SHALL have port sio_d_out, output, 1: SCCB data value.
REQ-013 SHALL have port sio_d_oe, output, 1: data-pin drive enable; the tristate buffer is at top level.
REQ-014 SHALL have port sio_d_in, input, 1: sampled data pin.

Function
REQ-015 SHALL implement states WAIT_INIT, IDLE, LOAD, START, BITS, STOP, DONE.
REQ-016 WAIT_INIT: a 16-bit counter runs to INIT_DLY-1, then the block goes to DONE, issuing the first SCCB_done so the config sequencer starts.
REQ-017 IDLE: sio_c=1, sio_d_out=1, sio_d_oe=1, busy=0; on data_vld=1 go to LOAD.
REQ-018 LOAD (exactly one cycle): capture addr and value into a 27-bit shift register {DEV_ID,1'b1,addr,1'b1,value,1'b1}, since upstream addr/value are valid one cycle after data_vld; go to START.
REQ-019 A quarter counter SHALL count 0..QTR_DIV-1; the phase index q (0..3) advances on counter wrap.
REQ-020 START quarters: q0 c=1 d=1; q1 c=1 d=0; q2 c=0 d=0; q3 c=0 d=0.
REQ-021 BITS sends 27 bits MSB-first; per bit, sio_d_out changes only at q0 entry; c=0 in q0-q1 and c=1 in q2-q3.
REQ-022 Bit indices 8, 17 and 26 (the don't-care/ACK slots) SHALL drive sio_d_oe=0; all other bits drive oe=1.
REQ-023 STOP quarters: q0 c=0 d=0; q1 c=1 d=0; q2 c=1 d=1; q3 c=1 d=1 (bus-free time).
REQ-024 DONE: SCCB_done=1 for exactly one cycle, then IDLE.
REQ-025 Transfer latency from data_vld to SCCB_done = 1 + 1 + 116*QTR_DIV + 1 cycles.
REQ-026 busy=1 in LOAD through STOP.
REQ-027 data_vld while busy or in WAIT_INIT SHALL be ignored; no queueing.
REQ-028 data_vld in the same cycle as the DONE pulse SHALL be ignored; it is accepted only in IDLE.
REQ-029 A 5-bit bit counter SHALL reach 26 then exit BITS; it SHALL never wrap during a transfer.

Reset
REQ-030 On rst=1 at a clk edge: state=WAIT_INIT, all counters=0, shift register=0.
REQ-031 On rst=1 at a clk edge, outputs SHALL be: sio_c=1, sio_d_out=1, sio_d_oe=1, SCCB_done=0, busy=0.
REQ-032 Reset mid-transfer SHALL abort immediately: the bus returns to idle-high with no STOP generated, and INIT_DLY restarts.
REQ-033 nack (when present) SHALL reset to 0.

Configuration
REQ-034 Macro SCCB_ACK_CHECK_EN SHALL control ACK checking.
REQ-035 With SCCB_ACK_CHECK_EN defined: output nack (1 bit) is added; sio_d_in is sampled at the last cycle of q2 of bits 8, 17 and 26.
REQ-036 With SCCB_ACK_CHECK_EN defined: any sampled 1 sets nack, which holds until the next LOAD clears it; the transfer still completes normally.
REQ-037 Without SCCB_ACK_CHECK_EN: no nack port, and sio_d_in is unused.

Verification
REQ-038 QTR_DIV=4, INIT_DLY=10, reset released: SCCB_done pulses once, at cycle 11 after release; busy=0 throughout.
REQ-039 data_vld, then addr=8'h12 and value=8'h14 the next cycle: decoded SCL-high samples = 0x42,x,0x12,x,0x14,x; START and STOP edges are correct; SCCB_done arrives 467 cycles after data_vld.
REQ-040 data_vld pulsed during BITS: no effect; exactly one SCCB_done per accepted request.
REQ-041 rst asserted in bit 10 of a transfer: the next cycle shows sio_c=1, sio_d_out=1, busy=0, with no SCCB_done until INIT_DLY expires.
REQ-042 SCCB_ACK_CHECK_EN defined, sio_d_in=1 only during bit 17: nack=1 after the transfer; the next LOAD clears it to 0.
REQ-043 Sequencer-in-loop for 3 writes: three transfers back-to-back, with each data_vld following its SCCB_done by 2 cycles.
